seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader.sv | 184 ++++++++++++++++++
 tb/tb_seg7_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// seg7_reader: recovers a 4-digit hex value by watching a scanned,
// multiplexed active-low 7-segment display.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   seg[6:0]     active-low segments, bit6 = a .. bit0 = g
//   an[3:0]      active-low digit enables, digit i when an = ~(1 << i)
//   value[15:0]  recovered frame, digit3 in [15:12], digit0 in [3:0]
//   value_valid  frame present; value/digit_err held while high
//   value_ready  consumer acceptance
//   digit_err    bit i set when digit i held an unknown pattern

module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        value_valid,
  input  logic        value_ready,
  output logic [3:0]  digit_err
);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [7:0] SAT = 8'(STABLE_CYCLES);

  logic [6:0]  seg_q;
  logic [6:0]  seg_p;
  logic [3:0]  an_q;
  logic [3:0]  an_p;
  logic [7:0]  cnt;

  logic        sel_ok;
  logic [1:0]  idx;
  logic [3:0]  mask;
  logic        same;
  logic        cap;

  logic [3:0]  nib;
  logic        bad;

  logic [15:0] pend;
  logic [3:0]  perr;
  logic [3:0]  col;

  state_t      state;
  state_t      state_n;
  logic        load;

  // One input stage, plus the previous registered sample
  // used for the stability comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 7'd0;
      an_q  <= 4'd0;
      seg_p <= 7'd0;
      an_p  <= 4'd0;
    end else begin
      seg_q <= seg;
      an_q  <= an;
      seg_p <= seg_q;
      an_p  <= an_q;
    end
  end

  // Exactly one enable low selects a digit.
  always_comb begin
    sel_ok = 1'b1;
    idx    = 2'd0;
    unique case (1'b1)
      an_q == 4'b1110: idx = 2'd0;
      an_q == 4'b1101: idx = 2'd1;
      an_q == 4'b1011: idx = 2'd2;
      an_q == 4'b0111: idx = 2'd3;
      default:         sel_ok = 1'b0;
    endcase
  end

  assign mask = 4'b0001 << idx;
  assign same = (seg_q == seg_p) && (an_q == an_p);

  // Capture fires only on the step into saturation,
  // so a long dwell produces a single capture.
  assign cap = sel_ok && same && (cnt == SAT - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (!sel_ok) begin
      cnt <= 8'd0;
    end else if (!same) begin
      cnt <= 8'd1;
    end else if (cnt != SAT) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Inverse of the hex-to-7seg table.
  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (seg_q)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default:    bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 16'h0000;
      perr <= 4'h0;
    end else if (cap) begin
      pend[{idx, 2'b00} +: 4] <= nib;
      perr[idx]               <= bad;
    end
  end

  // A capture landing on the load edge starts the next
  // frame rather than being dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= 4'h0;
    end else if (load) begin
      col <= cap ? mask : 4'h0;
    end else if (cap) begin
      col <= col | mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      COLLECT: if (&col)       state_n = PRESENT;
      PRESENT: if (value_ready) state_n = COLLECT;
      default:                 state_n = COLLECT;
    endcase
  end

  always_comb begin
    value_valid = (state == PRESENT);
    load        = (state == COLLECT) && (&col);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value     <= 16'h0000;
      digit_err <= 4'h0;
    end else if (load) begin
      value     <= pend;
      digit_err <= perr;
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed scans of a multiplexed display,
// checked against a frame-level model and literal expectations.

module tb_seg7_reader;

  localparam int S = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic [3:0]  digit_err;

  int checks = 0;
  int failures = 0;

  logic [6:0] pat [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_reader #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sel(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  // Frame model: counts how long each raw (an, seg) pair is held,
  // records a digit once its dwell reaches S, and queues a frame
  // whenever all four digits have been seen.
  logic [19:0] q [$];
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  int          m_run;
  logic [15:0] m_val;
  logic [3:0]  m_err;
  logic [3:0]  m_col;

  always @(posedge clk or posedge rst) begin
    int d;
    logic [3:0] n;
    logic b;
    if (rst) begin
      q.delete();
      m_an  = 4'hF;
      m_seg = 7'd0;
      m_run = 0;
      m_val = 16'h0;
      m_err = 4'h0;
      m_col = 4'h0;
    end else begin
      if (value_valid && value_ready && q.size() > 0)
        void'(q.pop_front());
      d = -1;
      for (int i = 0; i < 4; i++)
        if (an == sel(i)) d = i;
      if (d < 0) m_run = 0;
      else if (an == m_an && seg == m_seg) m_run++;
      else m_run = 1;
      m_an  = an;
      m_seg = seg;
      if (d >= 0 && m_run == S) begin
        n = 4'h0;
        b = 1'b1;
        for (int k = 0; k < 16; k++)
          if (pat[k] == seg) begin
            n = 4'(k);
            b = 1'b0;
          end
        m_val[d*4 +: 4] = n;
        m_err[d]        = b;
        m_col[d]        = 1'b1;
        if (m_col == 4'hF) begin
          q.push_back({m_err, m_val});
          m_col = 4'h0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && value_valid) begin
      chk("model_has_frame", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        chk("cmp_value", value, q[0][15:0]);
        chk("cmp_err", digit_err, q[0][19:16]);
      end
    end
  end

  task automatic drive(input int i, input logic [6:0] p, input int n);
    an  = sel(i);
    seg = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an  = 4'hF;
    seg = BLANK;
    repeat (n) @(negedge clk);
  endtask

  // Holds one digit for n cycles, noting when value_valid first
  // rises, the frame shown then, and how many cycles it was high.
  task automatic hold_last(input int i, input logic [6:0] p,
                           input int n, output int at,
                           output logic [15:0] v,
                           output logic [3:0] e, output int hi);
    at = -1;
    v  = 16'h0;
    e  = 4'h0;
    hi = 0;
    an  = sel(i);
    seg = p;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (value_valid) begin
        hi++;
        if (at < 0) begin
          at = k;
          v  = value;
          e  = digit_err;
        end
      end
    end
  endtask

  initial begin
    int at;
    int hi;
    int cz;
    logic [15:0] v;
    logic [3:0] e;

    rst = 1'b1;
    an  = 4'hF;
    seg = BLANK;
    value_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_value", value, 16'h0000);
    chk("reset_valid", value_valid, 0);
    chk("reset_err", digit_err, 4'h0);
    rst = 1'b0;
    idle(3);

    // Basic scan, latency and single pulse.
    drive(3, pat[1], 8);
    drive(2, pat[2], 8);
    drive(1, pat[10], 8);
    hold_last(0, pat[15], 8, at, v, e, hi);
    chk("scan_latency", at, S + 2);
    chk("scan_value", v, 16'h12AF);
    chk("scan_err", e, 4'h0);
    chk("scan_pulse", hi, 1);
    idle(4);

    // Glitch shorter than the dwell is ignored.
    drive(3, pat[0], 8);
    drive(2, pat[0], 8);
    drive(1, pat[5], 3);
    drive(1, pat[10], 8);
    hold_last(0, pat[0], 8, at, v, e, hi);
    chk("glitch_seen", 32'(at > 0), 1);
    chk("glitch_value", v, 16'h00A0);
    chk("glitch_err", e, 4'h0);
    idle(4);

    // Blank digit flags an error.
    drive(3, pat[0], 8);
    drive(2, BLANK, 8);
    drive(1, pat[0], 8);
    hold_last(0, pat[0], 8, at, v, e, hi);
    chk("blank_seen", 32'(at > 0), 1);
    chk("blank_value", v, 16'h0000);
    chk("blank_err", e, 4'b0100);
    idle(4);

    // Invalid selects never count.
    hi = 0;
    cz = 0;
    an  = 4'b0011;
    seg = pat[1];
    for (int k = 0; k < 20; k++) begin
      if (k == 10) an = 4'hF;
      @(negedge clk);
      if (value_valid) hi++;
      if (dut.cnt != 8'd0) cz++;
    end
    chk("invsel_valid", hi, 0);
    chk("invsel_cnt", cz, 0);

    // Back-pressure: second frame waits behind the first.
    value_ready = 1'b0;
    drive(3, pat[1], 8);
    drive(2, pat[2], 8);
    drive(1, pat[3], 8);
    hold_last(0, pat[4], 8, at, v, e, hi);
    chk("bp_first", v, 16'h1234);
    drive(3, pat[5], 8);
    drive(2, pat[6], 8);
    drive(1, pat[7], 8);
    drive(0, pat[8], 8);
    idle(3);
    chk("bp_hold_valid", value_valid, 1);
    chk("bp_hold_value", value, 16'h1234);
    value_ready = 1'b1;
    @(negedge clk);
    value_ready = 1'b0;
    chk("bp_drop", value_valid, 0);
    @(negedge clk);
    chk("bp_next_valid", value_valid, 1);
    chk("bp_next_value", value, 16'h5678);
    value_ready = 1'b1;
    idle(3);

    // Asynchronous reset discards held and partial data.
    value_ready = 1'b0;
    drive(3, pat[11], 8);
    drive(2, BLANK, 8);
    drive(1, pat[12], 8);
    hold_last(0, pat[13], 8, at, v, e, hi);
    chk("pre_rst_value", v, 16'hB0CD);
    chk("pre_rst_err", e, 4'b0100);
    drive(3, pat[9], 8);
    drive(2, pat[8], 8);
    drive(1, pat[7], 8);
    an  = 4'hF;
    seg = BLANK;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_value", value, 16'h0000);
    chk("rst_async_valid", value_valid, 0);
    chk("rst_async_err", digit_err, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    value_ready = 1'b1;
    hold_last(0, pat[14], 12, at, v, e, hi);
    chk("post_rst_partial", hi, 0);
    drive(3, pat[9], 8);
    drive(2, pat[8], 8);
    hold_last(1, pat[7], 8, at, v, e, hi);
    chk("post_rst_latency", at, S + 2);
    chk("post_rst_value", v, 16'h987E);
    chk("post_rst_err", e, 4'h0);
    idle(6);

    chk("frames_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
